// File: rtl/snn_epoch_sequencer.sv
// snn_epoch_sequencer
// Feeds the train_test_classify SNN core with a run of images. Each image
// (WORDS = M/4 packed 32-bit words) is first buffered from the host stream,
// then announced with start_main and replayed to the core as one contiguous
// valid_image burst. After the core reports valid_all, the result is captured,
// GAP idle cycles pass, and the next image is loaded until num_epochs images
// have been processed.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   run, abort          sequence start pulse / synchronous abort to IDLE
//   mode, num_epochs    sequence configuration, latched on an accepted run
//   img_word/img_label/img_valid/img_ready   host image stream (valid/ready)
//   start_main, train_test_classify, test_label, image_in, valid_image
//                       registered core-side drive
//   valid_all, image_label   core completion and classified label
//   busy, epoch_cnt, correct_cnt, result_label, result_valid, done,
//   timeout_err         status to the host
module snn_epoch_sequencer #(
    parameter int M       = 784,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        abort,
    input  logic [1:0]  mode,
    input  logic [15:0] num_epochs,
    input  logic [31:0] img_word,
    input  logic [7:0]  img_label,
    input  logic        img_valid,
    output logic        img_ready,
    output logic        start_main,
    output logic [1:0]  train_test_classify,
    output logic [7:0]  test_label,
    output logic [31:0] image_in,
    output logic        valid_image,
    input  logic        valid_all,
    input  logic [7:0]  image_label,
    output logic        busy,
    output logic [15:0] epoch_cnt,
    output logic [15:0] correct_cnt,
    output logic [7:0]  result_label,
    output logic        result_valid,
    output logic        done,
    output logic        timeout_err
);
    localparam int WORDS = M / 4;
    localparam int IDX_W = $clog2(WORDS + 1);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] WORDS_IDX = IDX_W'(WORDS);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_STREAM, S_WAIT, S_GAP, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       num_ep_q, num_ep_d;
    logic              img_ready_q, img_ready_d;
    logic              start_main_q, start_main_d;
    logic              valid_image_q, valid_image_d;
    logic [31:0]       image_in_q, image_in_d;
    logic [7:0]        test_label_q, test_label_d;
    logic [15:0]       epoch_cnt_q, epoch_cnt_d;
    logic [15:0]       correct_cnt_q, correct_cnt_d;
    logic [7:0]        result_label_q, result_label_d;
    logic              result_valid_q, result_valid_d;
    logic              done_q, done_d;
    logic              timeout_err_q, timeout_err_d;
    logic              busy_q, busy_d;

    logic [31:0]       img_buf [WORDS];
    logic              xfer;

    // A host word is only taken while loading; abort discards the buffer anyway.
    assign xfer = img_valid & img_ready_q & (state_q == S_LOAD) & ~abort;

    // Image buffer carries data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            img_buf[wr_idx_q] <= img_word;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_idx_d       = wr_idx_q;
        rd_idx_d       = rd_idx_q;
        gap_cnt_d      = gap_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        mode_d         = mode_q;
        num_ep_d       = num_ep_q;
        img_ready_d    = img_ready_q;
        start_main_d   = 1'b0;
        valid_image_d  = 1'b0;
        image_in_d     = image_in_q;
        test_label_d   = test_label_q;
        epoch_cnt_d    = epoch_cnt_q;
        correct_cnt_d  = correct_cnt_q;
        result_label_d = result_label_q;
        result_valid_d = 1'b0;
        done_d         = 1'b0;
        timeout_err_d  = timeout_err_q;

        if (abort) begin
            state_d     = S_IDLE;
            img_ready_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run && (mode != 2'd0) && (num_epochs != 16'd0)) begin
                        mode_d        = mode;
                        num_ep_d      = num_epochs;
                        epoch_cnt_d   = 16'd0;
                        correct_cnt_d = 16'd0;
                        timeout_err_d = 1'b0;
                        wr_idx_d      = '0;
                        img_ready_d   = 1'b1;
                        state_d       = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        wr_idx_d = wr_idx_q + 1'b1;
                        if (wr_idx_q == '0) begin
                            test_label_d = img_label;
                        end
                        if (wr_idx_q == LAST_IDX) begin
                            img_ready_d  = 1'b0;
                            start_main_d = 1'b1;
                            state_d      = S_START;
                        end
                    end
                end
                S_START: begin
                    // First word goes out the cycle after start_main.
                    valid_image_d = 1'b1;
                    image_in_d    = img_buf[0];
                    rd_idx_d      = IDX_W'(1);
                    state_d       = S_STREAM;
                end
                S_STREAM: begin
                    if (rd_idx_q == WORDS_IDX) begin
                        wait_cnt_d = '0;
                        state_d    = S_WAIT;
                    end else begin
                        valid_image_d = 1'b1;
                        image_in_d    = img_buf[rd_idx_q];
                        rd_idx_d      = rd_idx_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    // valid_all wins over a coincident timeout expiry.
                    if (valid_all) begin
                        epoch_cnt_d    = epoch_cnt_q + 16'd1;
                        result_label_d = image_label;
                        result_valid_d = 1'b1;
                        if ((mode_q != 2'd1) && (image_label == test_label_q) &&
                            (correct_cnt_q != 16'hFFFF)) begin
                            correct_cnt_d = correct_cnt_q + 16'd1;
                        end
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else if (wait_cnt_q == TO_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        if (epoch_cnt_q == num_ep_q) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            wr_idx_d    = '0;
                            img_ready_d = 1'b1;
                            state_d     = S_LOAD;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d     = S_IDLE;
                    img_ready_d = 1'b0;
                end
            endcase
        end

        // Mode is presented to the core only while a sequence is active.
        if (state_d == S_IDLE) begin
            mode_d = 2'd0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            wr_idx_q       <= '0;
            rd_idx_q       <= '0;
            gap_cnt_q      <= '0;
            wait_cnt_q     <= '0;
            mode_q         <= 2'd0;
            num_ep_q       <= 16'd0;
            img_ready_q    <= 1'b0;
            start_main_q   <= 1'b0;
            valid_image_q  <= 1'b0;
            image_in_q     <= 32'd0;
            test_label_q   <= 8'd0;
            epoch_cnt_q    <= 16'd0;
            correct_cnt_q  <= 16'd0;
            result_label_q <= 8'd0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_idx_q       <= wr_idx_d;
            rd_idx_q       <= rd_idx_d;
            gap_cnt_q      <= gap_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            mode_q         <= mode_d;
            num_ep_q       <= num_ep_d;
            img_ready_q    <= img_ready_d;
            start_main_q   <= start_main_d;
            valid_image_q  <= valid_image_d;
            image_in_q     <= image_in_d;
            test_label_q   <= test_label_d;
            epoch_cnt_q    <= epoch_cnt_d;
            correct_cnt_q  <= correct_cnt_d;
            result_label_q <= result_label_d;
            result_valid_q <= result_valid_d;
            done_q         <= done_d;
            timeout_err_q  <= timeout_err_d;
            busy_q         <= busy_d;
        end
    end

    assign img_ready           = img_ready_q;
    assign start_main          = start_main_q;
    assign train_test_classify = mode_q;
    assign test_label          = test_label_q;
    assign image_in            = image_in_q;
    assign valid_image         = valid_image_q;
    assign busy                = busy_q;
    assign epoch_cnt           = epoch_cnt_q;
    assign correct_cnt         = correct_cnt_q;
    assign result_label        = result_label_q;
    assign result_valid        = result_valid_q;
    assign done                = done_q;
    assign timeout_err         = timeout_err_q;

endmodule

// File: tb/tb_snn_epoch_sequencer.sv
// Testbench for snn_epoch_sequencer: table of full sequences plus hand-written
// timeout, abort, ignored-run and mid-sequence reset cases. Host words are
// pushed to a scoreboard queue on transfer and popped as the core-side stream
// appears.
module tb_snn_epoch_sequencer;
    localparam int M       = 784;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 100;
    localparam int WORDS   = M / 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        run, abort, img_valid, valid_all;
    logic [1:0]  mode;
    logic [15:0] num_epochs;
    logic [31:0] img_word;
    logic [7:0]  img_label, image_label;
    logic        img_ready, start_main, valid_image, busy, result_valid, done, timeout_err;
    logic [1:0]  train_test_classify;
    logic [7:0]  test_label, result_label;
    logic [31:0] image_in;
    logic [15:0] epoch_cnt, correct_cnt;

    snn_epoch_sequencer #(.M(M), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .run(run), .abort(abort), .mode(mode),
        .num_epochs(num_epochs), .img_word(img_word), .img_label(img_label),
        .img_valid(img_valid), .img_ready(img_ready), .start_main(start_main),
        .train_test_classify(train_test_classify), .test_label(test_label),
        .image_in(image_in), .valid_image(valid_image), .valid_all(valid_all),
        .image_label(image_label), .busy(busy), .epoch_cnt(epoch_cnt),
        .correct_cnt(correct_cnt), .result_label(result_label),
        .result_valid(result_valid), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] nep;
        bit          stall;
        logic [7:0]  lbl0, lbl1, core0, core1;
        logic [15:0] exp_correct;
        logic [7:0]  exp_result;
    } vec_t;

    vec_t        tbl [3];
    logic [31:0] exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          ld_cnt = 0;
    int          starts = 0;
    int          done_cnt = 0;
    int          rv_cnt = 0;
    bit          cut_ok = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name, input int act, input int exp);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Core-side monitor: stream contents, contiguity, pulse counting.
    initial begin
        bit prev_start, prev_valid;
        int slen;
        prev_start = 0; prev_valid = 0; slen = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_start = 0; prev_valid = 0; slen = 0;
            end else begin
                if (start_main) begin
                    starts++;
                    check("start_after_full_load", ld_cnt, WORDS);
                end
                if (valid_image) begin
                    if (!prev_valid) check("stream_first_after_start", 32'(prev_start), 1);
                    slen++;
                    if (exp_q.size() == 0) fail_now("stream_word_unexpected", slen, 0);
                    else check("image_in", image_in, exp_q.pop_front());
                end else if (prev_valid) begin
                    if (!cut_ok) check("stream_len", slen, WORDS);
                    cut_ok = 0;
                    slen = 0;
                end
                if (result_valid) rv_cnt++;
                if (done) done_cnt++;
                prev_start = start_main;
                prev_valid = valid_image;
            end
        end
    end

    task automatic do_run(input logic [1:0] m, input logic [15:0] n);
        mode = m; num_epochs = n; run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    task automatic load_image(input logic [31:0] base, input logic [7:0] lbl,
                              input bit stall, output bit ok);
        int  i = 0;
        int  guard = 0;
        bit  tog = 0;
        bit  xf;
        ld_cnt = 0;
        ok = 1;
        while (i < WORDS) begin
            img_word = base + 32'(i);
            img_label = lbl;
            tog = ~tog;
            img_valid = stall ? tog : 1'b1;
            xf = img_valid && img_ready;
            @(posedge clk); #1;
            if (xf) begin
                exp_q.push_back(base + 32'(i));
                i++;
                ld_cnt++;
            end
            guard++;
            if (guard > 4 * WORDS + 50) begin
                fail_now("load_timeout", i, WORDS);
                ok = 0;
                break;
            end
        end
        img_valid = 1'b0;
    endtask

    task automatic wait_stream_end(output bit ok);
        bit seen = 0;
        ok = 0;
        for (int c = 0; c < 3 * WORDS; c++) begin
            @(posedge clk); #1;
            if (valid_image) seen = 1;
            else if (seen) begin
                ok = 1;
                return;
            end
        end
        fail_now("stream_end_timeout", 0, 1);
    endtask

    task automatic core_done(input logic [7:0] lbl);
        valid_all = 1'b1; image_label = lbl;
        @(posedge clk); #1;
        valid_all = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 3 * GAP + 10) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_entry(input int e);
        vec_t v;
        int   s0, d0, rv0, n;
        bit   ok;
        logic [7:0] lbl, cl;
        v = tbl[e];
        s0 = starts; d0 = done_cnt; rv0 = rv_cnt;
        do_run(v.mode, v.nep);
        check("run_busy", busy, 1);
        check("run_mode_out", train_test_classify, v.mode);
        check("run_img_ready", img_ready, 1);
        for (int img = 0; img < int'(v.nep); img++) begin
            lbl = (img == 0) ? v.lbl0 : v.lbl1;
            cl  = (img == 0) ? v.core0 : v.core1;
            load_image((32'(e) << 16) | (32'(img) << 12), lbl, v.stall, ok);
            if (!ok) return;
            wait_stream_end(ok);
            if (!ok) return;
            check("test_label", test_label, lbl);
            repeat (2) begin @(posedge clk); #1; end
            core_done(cl);
            check("result_valid", result_valid, 1);
            check("result_label", result_label, cl);
            check("epoch_cnt_step", epoch_cnt, img + 1);
            @(posedge clk); #1;
            check("result_valid_pulse", result_valid, 0);
        end
        wait_done(n);
        check("done_pulse", done, 1);
        check("done_after_gap", n, GAP);
        @(posedge clk); #1;
        check("done_width", done, 0);
        check("end_busy", busy, 0);
        check("end_mode_out", train_test_classify, 0);
        check("epoch_cnt", epoch_cnt, v.nep);
        check("correct_cnt", correct_cnt, v.exp_correct);
        check("result_label_last", result_label, v.exp_result);
        check("start_main_count", starts - s0, v.nep);
        check("done_count", done_cnt - d0, 1);
        check("result_valid_count", rv_cnt - rv0, v.nep);
    endtask

    initial begin
        int  n, d0, s0, cnt;
        bit  ok;
        tbl[0] = '{2'd1, 16'd2, 1'b0, 8'd9, 8'd9, 8'd9, 8'd2, 16'd0, 8'd2};
        tbl[1] = '{2'd2, 16'd1, 1'b1, 8'd4, 8'd0, 8'd4, 8'd0, 16'd1, 8'd4};
        tbl[2] = '{2'd3, 16'd2, 1'b0, 8'd5, 8'd7, 8'd5, 8'd3, 16'd1, 8'd3};

        rst = 1'b0; run = 0; abort = 0; mode = 0; num_epochs = 0;
        img_word = 0; img_label = 0; img_valid = 0; valid_all = 0; image_label = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_img_ready", img_ready, 0);
        check("rst_start_main", start_main, 0);
        check("rst_valid_image", valid_image, 0);
        check("rst_mode_out", train_test_classify, 0);
        check("rst_counters", {epoch_cnt, correct_cnt}, 0);
        check("rst_pulses", {result_valid, done, timeout_err}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int e = 0; e < 3; e++) run_entry(e);

        // Timeout: core never answers.
        d0 = done_cnt;
        do_run(2'd1, 16'd1);
        load_image(32'hA000_0000, 8'd1, 1'b0, ok);
        wait_stream_end(ok);
        n = 0;
        while (!timeout_err && n < 3 * TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_err", timeout_err, 1);
        check("timeout_cycles", n, TIMEOUT);
        check("timeout_busy", busy, 0);
        check("timeout_mode_out", train_test_classify, 0);
        check("timeout_epoch", epoch_cnt, 0);
        check("timeout_no_done", done_cnt - d0, 0);

        // Next run clears timeout_err; abort it mid-stream.
        do_run(2'd2, 16'd1);
        check("run_clears_timeout", timeout_err, 0);
        load_image(32'hB000_0000, 8'h11, 1'b0, ok);
        cnt = 0;
        for (int c = 0; c < 3 * WORDS && cnt < 50; c++) begin
            @(posedge clk); #1;
            if (valid_image) cnt++;
        end
        check("abort_reached_word50", cnt, 50);
        cut_ok = 1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        check("abort_valid_image", valid_image, 0);
        check("abort_busy", busy, 0);
        check("abort_img_ready", img_ready, 0);
        check("abort_mode_out", train_test_classify, 0);
        repeat (3) begin @(posedge clk); #1; end

        // Fresh run after abort reloads the whole image.
        s0 = starts; d0 = done_cnt;
        do_run(2'd2, 16'd1);
        load_image(32'hC000_0000, 8'h22, 1'b1, ok);
        wait_stream_end(ok);
        core_done(8'h22);
        check("post_abort_correct", correct_cnt, 1);
        wait_done(n);
        check("post_abort_done", done, 1);
        check("post_abort_starts", starts - s0, 1);
        @(posedge clk); #1;

        // Ignored runs.
        do_run(2'd0, 16'd5);
        check("mode0_ignored", {busy, img_ready}, 0);
        do_run(2'd1, 16'd0);
        check("nep0_ignored", {busy, train_test_classify}, 0);
        do_run(2'd1, 16'd1);
        check("run_accepted", busy, 1);
        do_run(2'd3, 16'd7);
        check("run_busy_ignored", train_test_classify, 1);

        // Asynchronous reset while waiting on the core.
        d0 = done_cnt;
        load_image(32'hD000_0000, 8'd3, 1'b0, ok);
        wait_stream_end(ok);
        repeat (5) begin @(posedge clk); #1; end
        check("pre_rst_result_label", result_label, 8'h22);
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_mode_test_label", {train_test_classify, test_label}, 0);
        check("arst_counters", {epoch_cnt, correct_cnt}, 0);
        check("arst_result", {result_label, result_valid, done, timeout_err}, 0);
        check("arst_core_side", {img_ready, start_main, valid_image}, 0);
        check("arst_image_in", image_in, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check("arst_no_done", done_cnt - d0, 0);
        check("arst_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL global_timeout: got %0d expected %0d", vectors, 0);
        $fatal(1, "bench time limit");
    end
endmodule
